ssg_mixer: RTL

Parametrised, time-multiplexed channel mixer for the SSG sound generator. It takes one sample per channel from the per-channel wave/noise multiplexers, scales each by a per-channel volume register, and accumulates one channel per cycle. It then produces a saturated output word with a valid pulse and a clip flag. It sits between the output multiplexing stage and the DAC/PWM output stage, and replaces the fixed 4-channel wrap-around adder with an N-channel, volume-controlled, clipping-aware mixer.

---
 rtl/ssg_pkg.sv | 34 +++
 rtl/ssg_volume_scaler.sv | 25 ++
 rtl/ssg_mixer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ssg_pkg.sv
// ssg_pkg: shared types and helpers for the SSG channel mixer.
//   state_t     : mixer frame state (IDLE / ACCUM / DONE)
//   idx_width   : width of the channel index for a given channel count
//   acc_width   : accumulator width that holds the full unscaled sum
//   saturate    : clamp a value to the largest OUT_W-bit unsigned number
//   exceeds     : 1 when a value does not fit in OUT_W unsigned bits
package ssg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // One extra bit over sample_w + log2(channels) so the sum never wraps.
    function automatic int acc_width(input int sample_w, input int channels);
        return sample_w + $clog2(channels) + 1;
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] value, input int out_w);
        logic [31:0] max_val;
        max_val = (32'd1 << out_w) - 32'd1;
        return (value > max_val) ? max_val : value;
    endfunction

    function automatic logic exceeds(input logic [31:0] value, input int out_w);
        return value > ((32'd1 << out_w) - 32'd1);
    endfunction

endpackage

// File: rtl/ssg_volume_scaler.sv
// ssg_volume_scaler: combinational volume scaling of one channel sample.
//   sample : unsigned channel sample (SAMPLE_W bits)
//   vol    : volume register value; gain is (vol+1)/2^VOL_W
//   term   : scaled sample, (sample * (vol+1)) >> VOL_W, SAMPLE_W bits
module ssg_volume_scaler #(
    parameter int SAMPLE_W = 6,
    parameter int VOL_W    = 4
) (
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [VOL_W-1:0]    vol,
    output logic [SAMPLE_W-1:0] term
);

    localparam int PROD_W = SAMPLE_W + VOL_W + 1;

    logic [PROD_W-1:0] gain;
    logic [PROD_W-1:0] prod;

    assign gain = PROD_W'(vol) + PROD_W'(1);
    assign prod = PROD_W'(sample) * gain;

    // Gain never exceeds 1.0, so the shifted product always fits SAMPLE_W bits.
    assign term = SAMPLE_W'(prod >> VOL_W);

endmodule

// File: rtl/ssg_mixer.sv
// ssg_mixer: time-multiplexed, volume-controlled, saturating N-channel mixer.
//   CLK, RST    : clock and synchronous active-high reset
//   Samples     : packed channel samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   ChanEnable  : per-channel enable (0 = channel contributes nothing)
//   Start       : begins one mix frame when idle
//   VolWE/VolAddr/VolData : volume register write port, usable at any time
//   BUSY        : frame in progress (ACCUM or DONE)
//   WaveOut     : saturated mix result, held between frames
//   Valid       : one-cycle pulse marking a fresh WaveOut
//   Clip        : set with WaveOut when the frame saturated
//   Overrun     : one-cycle pulse after a Start that arrived while busy
module ssg_mixer
    import ssg_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 6,
    parameter int VOL_W    = 4,
    parameter int OUT_W    = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CHANNELS*SAMPLE_W-1:0]   Samples,
    input  logic [CHANNELS-1:0]            ChanEnable,
    input  logic                           Start,
    input  logic                           VolWE,
    input  logic [idx_width(CHANNELS)-1:0] VolAddr,
    input  logic [VOL_W-1:0]               VolData,
    output logic                           BUSY,
    output logic [OUT_W-1:0]               WaveOut,
    output logic                           Valid,
    output logic                           Clip,
    output logic                           Overrun
);

    localparam int IDX_W = idx_width(CHANNELS);
    localparam int ACC_W = acc_width(SAMPLE_W, CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [ACC_W-1:0]     acc_q, acc_next;
    logic [SAMPLE_W-1:0]  samp_q [CHANNELS];
    logic [CHANNELS-1:0]  en_q;
    logic [VOL_W-1:0]     vol_q  [CHANNELS];
    logic [SAMPLE_W-1:0]  term;
    logic [OUT_W-1:0]     wave_q;
    logic                 clip_q;
    logic                 overrun_q;

    // One scaler shared by all channels; idx_q selects the channel each cycle.
    // The volume register is read before any same-cycle write lands, so a
    // write to the channel being accumulated takes effect next frame.
    ssg_volume_scaler #(
        .SAMPLE_W (SAMPLE_W),
        .VOL_W    (VOL_W)
    ) u_scaler (
        .sample (samp_q[idx_q]),
        .vol    (vol_q[idx_q]),
        .term   (term)
    );

    always_comb begin
        acc_next = acc_q;
        if (en_q[idx_q]) begin
            acc_next = acc_q + ACC_W'(term);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = ACCUM;
            ACCUM:   if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q     <= '0;
            acc_q     <= '0;
            wave_q    <= '0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                vol_q[k] <= '1;
            end
        end else begin
            overrun_q <= Start && (state_q != IDLE);

            // Address decode by loop: indices >= CHANNELS simply match nothing.
            for (int k = 0; k < CHANNELS; k++) begin
                if (VolWE && (VolAddr == IDX_W'(k))) begin
                    vol_q[k] <= VolData;
                end
            end

            case (state_q)
                IDLE: begin
                    if (Start) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            samp_q[k] <= Samples[k*SAMPLE_W +: SAMPLE_W];
                        end
                        en_q  <= ChanEnable;
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q + IDX_W'(1);
                    // Output is registered on the final add so that it is
                    // already visible while DONE raises Valid.
                    if (idx_q == LAST_IDX) begin
                        wave_q <= OUT_W'(saturate(32'(acc_next), OUT_W));
                        clip_q <= exceeds(32'(acc_next), OUT_W);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY    = (state_q != IDLE);
    assign Valid   = (state_q == DONE);
    assign WaveOut = wave_q;
    assign Clip    = clip_q;
    assign Overrun = overrun_q;

endmodule
